// File: rtl/nios2_debug_cmd_sched.sv
// ---------------------------------------------------------------------------
// nios2_debug_cmd_sched
//
// Purpose:
//   Debug command scheduler that sits between the debug slave's system-clock
//   logic and the on-chip instrumentation (OCI) register/memory port. There
//   are two command sources: JTAG commands that are already synchronised into
//   clk, and an optional local debug host. A round-robin arbiter picks one
//   source. The chosen command goes to the OCI as a single-cycle strobe. The
//   block then waits for an ack or a timeout and returns a 34-bit response to
//   whichever source issued the command. Only one command is in flight at a
//   time.
//
// Parameters:
//   TIMEOUT_CYCLES : WAIT cycles before a command is abandoned (2..1023)
//   HOST_ENABLE    : 1 enables the local host requester, 0 disables it
//
// Ports:
//   clk, reset                 : rising-edge clock, async active-high reset
//   j_valid/j_ready/j_ir/j_data: JTAG command channel
//   h_valid/h_ready/h_ir/h_data: host command channel
//   oci_cmd_valid/oci_ir/oci_data : command strobe and fields to the OCI
//   oci_ack/oci_rdata/oci_err  : OCI completion pulse, read data, error flag
//   j_rsp_valid/j_rsp_ready    : JTAG response handshake
//   h_rsp_valid/h_rsp_ready    : host response handshake
//   rsp_data                   : {timeout, err, rdata[31:0]} shared response
//   busy                       : high whenever the FSM is not idle
//   grant_id                   : 0 = JTAG, 1 = host (current or last grant)
// ---------------------------------------------------------------------------
module nios2_debug_cmd_sched #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int HOST_ENABLE    = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        j_valid,
  output logic        j_ready,
  input  logic [1:0]  j_ir,
  input  logic [37:0] j_data,

  input  logic        h_valid,
  output logic        h_ready,
  input  logic [1:0]  h_ir,
  input  logic [37:0] h_data,

  output logic        oci_cmd_valid,
  output logic [1:0]  oci_ir,
  output logic [37:0] oci_data,
  input  logic        oci_ack,
  input  logic [31:0] oci_rdata,
  input  logic        oci_err,

  output logic        j_rsp_valid,
  input  logic        j_rsp_ready,
  output logic        h_rsp_valid,
  input  logic        h_rsp_ready,
  output logic [33:0] rsp_data,

  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // The last WAIT count before the command is abandoned.
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);
  localparam logic       HOST_EN  = (HOST_ENABLE != 0);

  state_e      state_q, state_d;
  logic [1:0]  oci_ir_q, oci_ir_d;
  logic [37:0] oci_data_q, oci_data_d;
  logic [33:0] rsp_data_q, rsp_data_d;
  logic        grant_q, grant_d;
  logic        rr_host_q, rr_host_d;
  logic [9:0]  cnt_q, cnt_d;

  logic        h_valid_eff;
  logic        sel_host;
  logic        in_idle;
  logic        accept;
  logic        rsp_hs;

  // Arbitration and handshakes. A lone requester always wins. On a tie the
  // pointer decides, and the pointer always favours the requester that was
  // not served last. Ready is forced low while reset is asserted.
  always_comb begin
    h_valid_eff = h_valid & HOST_EN;
    sel_host    = h_valid_eff & (~j_valid | rr_host_q);
    in_idle     = (state_q == ST_IDLE) & ~reset;
    j_ready     = in_idle & j_valid & ~sel_host;
    h_ready     = in_idle & sel_host;
    accept      = j_ready | h_ready;
    // Only the granted requester's rsp_ready can complete the response.
    rsp_hs      = (state_q == ST_RESP) &
                  (grant_q ? (h_rsp_ready & HOST_EN) : j_rsp_ready);
  end

  // Next-state logic for the command FSM and its datapath registers.
  always_comb begin
    state_d    = state_q;
    oci_ir_d   = oci_ir_q;
    oci_data_d = oci_data_q;
    rsp_data_d = rsp_data_q;
    grant_d    = grant_q;
    rr_host_d  = rr_host_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_ISSUE;
          oci_ir_d   = sel_host ? h_ir   : j_ir;
          oci_data_d = sel_host ? h_data : j_data;
          grant_d    = sel_host;
        end
      end

      ST_ISSUE: begin
        // oci_ack is deliberately ignored here.
        state_d = ST_WAIT;
        cnt_d   = 10'd0;
      end

      ST_WAIT: begin
        // If an ack arrives in the same cycle as the timeout, the ack wins.
        if (oci_ack) begin
          rsp_data_d = {1'b0, oci_err, oci_rdata};
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = {1'b1, 1'b0, 32'h0000_0000};
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end

      ST_RESP: begin
        if (rsp_hs) begin
          state_d   = ST_IDLE;
          rr_host_d = ~grant_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      oci_ir_q   <= 2'd0;
      oci_data_q <= 38'd0;
      rsp_data_q <= 34'd0;
      grant_q    <= 1'b0;
      rr_host_q  <= 1'b0;
      cnt_q      <= 10'd0;
    end else begin
      state_q    <= state_d;
      oci_ir_q   <= oci_ir_d;
      oci_data_q <= oci_data_d;
      rsp_data_q <= rsp_data_d;
      grant_q    <= grant_d;
      rr_host_q  <= rr_host_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs are decoded directly from registered state, so they stay glitch-free.
  always_comb begin
    oci_cmd_valid = (state_q == ST_ISSUE);
    oci_ir        = oci_ir_q;
    oci_data      = oci_data_q;
    rsp_data      = rsp_data_q;
    j_rsp_valid   = (state_q == ST_RESP) & ~grant_q;
    h_rsp_valid   = (state_q == ST_RESP) & grant_q & HOST_EN;
    busy          = (state_q != ST_IDLE);
    grant_id      = grant_q;
  end

endmodule

// File: tb/tb_nios2_debug_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_nios2_debug_cmd_sched
//
// Directed testbench for nios2_debug_cmd_sched, built with TIMEOUT_CYCLES=8.
// Inputs are driven 1 time unit after the rising edge, and outputs are
// sampled after that. Each test task performs its own comparisons.
// ---------------------------------------------------------------------------
module tb_nios2_debug_cmd_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        j_valid, h_valid;
  logic        j_ready, h_ready;
  logic [1:0]  j_ir, h_ir;
  logic [37:0] j_data, h_data;
  logic        oci_cmd_valid;
  logic [1:0]  oci_ir;
  logic [37:0] oci_data;
  logic        oci_ack;
  logic [31:0] oci_rdata;
  logic        oci_err;
  logic        j_rsp_valid, j_rsp_ready;
  logic        h_rsp_valid, h_rsp_ready;
  logic [33:0] rsp_data;
  logic        busy;
  logic        grant_id;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nios2_debug_cmd_sched #(
    .TIMEOUT_CYCLES(8),
    .HOST_ENABLE   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .j_valid      (j_valid),
    .j_ready      (j_ready),
    .j_ir         (j_ir),
    .j_data       (j_data),
    .h_valid      (h_valid),
    .h_ready      (h_ready),
    .h_ir         (h_ir),
    .h_data       (h_data),
    .oci_cmd_valid(oci_cmd_valid),
    .oci_ir       (oci_ir),
    .oci_data     (oci_data),
    .oci_ack      (oci_ack),
    .oci_rdata    (oci_rdata),
    .oci_err      (oci_err),
    .j_rsp_valid  (j_rsp_valid),
    .j_rsp_ready  (j_rsp_ready),
    .h_rsp_valid  (h_rsp_valid),
    .h_rsp_ready  (h_rsp_ready),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    j_valid = 1'b1;
    h_valid = 1'b1;
    tick();
    tick();
    n_cmp++; if (j_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_j_ready: got %b want 0", j_ready); end
    n_cmp++; if (h_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_h_ready: got %b want 0", h_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (oci_cmd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_cmd_valid: got %b want 0", oci_cmd_valid); end
    n_cmp++; if (oci_ir !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_oci_ir: got %h want 0", oci_ir); end
    n_cmp++; if (oci_data !== 38'd0) begin n_fail++; $display("[TB] FAIL rst_oci_data: got %h want 0", oci_data); end
    n_cmp++; if (rsp_data !== 34'd0) begin n_fail++; $display("[TB] FAIL rst_rsp_data: got %h want 0", rsp_data); end
    n_cmp++; if (j_rsp_valid !== 1'b0 || h_rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rsp_valid: got j=%b h=%b want 0 0", j_rsp_valid, h_rsp_valid); end
    n_cmp++; if (grant_id !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_grant: got %b want 0", grant_id); end
    j_valid = 1'b0;
    h_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  // Both requesters stay valid from reset, so grants must alternate J,H,J,H.
  task automatic test_round_robin();
    logic exp_h;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    j_valid = 1'b1; j_ir = 2'd1; j_data = 38'h00_0000_0011;
    h_valid = 1'b1; h_ir = 2'd3; h_data = 38'h3F_FFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      exp_h = (i % 2) == 1;
      #1;
      n_cmp++; if (j_ready !== ~exp_h || h_ready !== exp_h) begin n_fail++; $display("[TB] FAIL rr_ready[%0d]: got j=%b h=%b want j=%b h=%b", i, j_ready, h_ready, ~exp_h, exp_h); end
      tick();
      n_cmp++; if (grant_id !== exp_h) begin n_fail++; $display("[TB] FAIL rr_grant[%0d]: got %b want %b", i, grant_id, exp_h); end
      n_cmp++; if (oci_ir !== (exp_h ? 2'd3 : 2'd1)) begin n_fail++; $display("[TB] FAIL rr_oci_ir[%0d]: got %0d want %0d", i, oci_ir, exp_h ? 2'd3 : 2'd1); end
      tick();
      oci_ack = 1'b1; oci_rdata = 32'(256 + i); oci_err = 1'b0;
      tick();
      oci_ack = 1'b0;
      n_cmp++; if (j_rsp_valid !== ~exp_h || h_rsp_valid !== exp_h) begin n_fail++; $display("[TB] FAIL rr_rsp_valid[%0d]: got j=%b h=%b want j=%b h=%b", i, j_rsp_valid, h_rsp_valid, ~exp_h, exp_h); end
      n_cmp++; if (rsp_data !== {2'b00, 32'(256 + i)}) begin n_fail++; $display("[TB] FAIL rr_rsp_data[%0d]: got %h want %h", i, rsp_data, {2'b00, 32'(256 + i)}); end
      if (exp_h) h_rsp_ready = 1'b1; else j_rsp_ready = 1'b1;
      tick();
      j_rsp_ready = 1'b0;
      h_rsp_ready = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_idle[%0d]: got busy=%b want 0", i, busy); end
    end
    j_valid = 1'b0;
    h_valid = 1'b0;
    tick();
  endtask

  task automatic test_jtag_only();
    j_valid = 1'b1; j_ir = 2'd2; j_data = 38'h2_0000_0ABC;
    #1;
    n_cmp++; if (j_ready !== 1'b1 || h_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL jo_ready: got j=%b h=%b want 1 0", j_ready, h_ready); end
    tick();
    j_valid = 1'b0;
    n_cmp++; if (oci_cmd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL jo_cmd_t1: got %b want 1", oci_cmd_valid); end
    n_cmp++; if (oci_data !== 38'h2_0000_0ABC) begin n_fail++; $display("[TB] FAIL jo_oci_data: got %h want 2_00000abc", oci_data); end
    n_cmp++; if (oci_ir !== 2'd2) begin n_fail++; $display("[TB] FAIL jo_oci_ir: got %0d want 2", oci_ir); end
    tick();
    n_cmp++; if (oci_cmd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL jo_cmd_t2: got %b want 0", oci_cmd_valid); end
    n_cmp++; if (j_rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL jo_rsp_early: got %b want 0", j_rsp_valid); end
    oci_ack = 1'b1; oci_rdata = 32'hDEADBEEF; oci_err = 1'b0;
    tick();
    oci_ack = 1'b0;
    n_cmp++; if (j_rsp_valid !== 1'b1 || h_rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL jo_rsp_valid: got j=%b h=%b want 1 0", j_rsp_valid, h_rsp_valid); end
    n_cmp++; if (rsp_data !== 34'h0_DEADBEEF) begin n_fail++; $display("[TB] FAIL jo_rsp_data: got %h want 0_deadbeef", rsp_data); end
    n_cmp++; if (oci_cmd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL jo_cmd_t3: got %b want 0", oci_cmd_valid); end
    j_rsp_ready = 1'b1;
    tick();
    j_rsp_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0 || j_rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL jo_idle: got busy=%b rsp_valid=%b want 0 0", busy, j_rsp_valid); end
  endtask

  task automatic test_timeout();
    j_valid = 1'b1; j_ir = 2'd0; j_data = 38'h0_1234_5678;
    #1;
    n_cmp++; if (j_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL to_ready: got %b want 1", j_ready); end
    tick();
    j_valid = 1'b0;
    repeat (8) tick();
    n_cmp++; if (j_rsp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL to_t9: got rsp_valid=%b busy=%b want 0 1", j_rsp_valid, busy); end
    tick();
    n_cmp++; if (j_rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL to_t10_valid: got %b want 1", j_rsp_valid); end
    n_cmp++; if (rsp_data !== 34'h2_0000_0000) begin n_fail++; $display("[TB] FAIL to_rsp_data: got %h want 2_00000000", rsp_data); end
    j_rsp_ready = 1'b1;
    tick();
    j_rsp_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL to_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_ack_timeout_tie();
    j_valid = 1'b1; j_ir = 2'd1; j_data = 38'h0_0000_0001;
    #1;
    tick();
    j_valid = 1'b0;
    repeat (8) tick();
    oci_ack = 1'b1; oci_rdata = 32'h0000_0001; oci_err = 1'b1;
    tick();
    oci_ack = 1'b0; oci_err = 1'b0;
    n_cmp++; if (j_rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL tie_valid: got %b want 1", j_rsp_valid); end
    n_cmp++; if (rsp_data !== 34'h1_0000_0001) begin n_fail++; $display("[TB] FAIL tie_rsp_data: got %h want 1_00000001", rsp_data); end
    j_rsp_ready = 1'b1;
    tick();
    j_rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    j_valid = 1'b1; j_ir = 2'd1; j_data = 38'h0_0000_00BB;
    #1;
    n_cmp++; if (j_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_j_ready: got %b want 1", j_ready); end
    tick();
    j_valid = 1'b0;
    h_valid = 1'b1; h_ir = 2'd2; h_data = 38'h15_5555_5555;
    tick();
    oci_ack = 1'b1; oci_rdata = 32'hCAFEF00D; oci_err = 1'b1;
    tick();
    oci_ack = 1'b0; oci_err = 1'b0;
    h_rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (rsp_data !== 34'h1_CAFEF00D || j_rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold[%0d]: got data=%h valid=%b want 1_cafef00d 1", k, rsp_data, j_rsp_valid); end
      n_cmp++; if (h_ready !== 1'b0 || h_rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_host_blocked[%0d]: got ready=%b rsp_valid=%b want 0 0", k, h_ready, h_rsp_valid); end
      tick();
    end
    h_rsp_ready = 1'b0;
    j_rsp_ready = 1'b1;
    #1;
    n_cmp++; if (h_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_hs_cycle_ready: got %b want 0", h_ready); end
    tick();
    j_rsp_ready = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || h_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_host_accept: got busy=%b h_ready=%b want 0 1", busy, h_ready); end
    tick();
    h_valid = 1'b0;
    n_cmp++; if (grant_id !== 1'b1 || oci_cmd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_host_grant: got grant=%b cmd=%b want 1 1", grant_id, oci_cmd_valid); end
    n_cmp++; if (oci_data !== 38'h15_5555_5555 || oci_ir !== 2'd2) begin n_fail++; $display("[TB] FAIL bp_host_cmd: got data=%h ir=%0d want 15_55555555 2", oci_data, oci_ir); end
    tick();
    oci_ack = 1'b1; oci_rdata = 32'h5A5A_0001;
    tick();
    oci_ack = 1'b0;
    n_cmp++; if (h_rsp_valid !== 1'b1 || j_rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_host_rsp: got h=%b j=%b want 1 0", h_rsp_valid, j_rsp_valid); end
    n_cmp++; if (rsp_data !== 34'h0_5A5A_0001) begin n_fail++; $display("[TB] FAIL bp_host_data: got %h want 0_5a5a0001", rsp_data); end
    h_rsp_ready = 1'b1;
    tick();
    h_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    h_valid = 1'b1; h_ir = 2'd3; h_data = 38'h2A_AAAA_AAAA;
    #1;
    n_cmp++; if (h_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rw_h_ready: got %b want 1", h_ready); end
    tick();
    h_valid = 1'b0;
    tick();
    tick();
    n_cmp++; if (grant_id !== 1'b1 || busy !== 1'b1 || oci_ir !== 2'd3) begin n_fail++; $display("[TB] FAIL rw_pre: got grant=%b busy=%b ir=%0d want 1 1 3", grant_id, busy, oci_ir); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || grant_id !== 1'b0) begin n_fail++; $display("[TB] FAIL rw_async_state: got busy=%b grant=%b want 0 0", busy, grant_id); end
    n_cmp++; if (oci_ir !== 2'd0 || oci_data !== 38'd0) begin n_fail++; $display("[TB] FAIL rw_async_cmd: got ir=%0d data=%h want 0 0", oci_ir, oci_data); end
    n_cmp++; if (rsp_data !== 34'd0 || h_rsp_valid !== 1'b0 || oci_cmd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rw_async_rsp: got data=%h valid=%b cmd=%b want 0 0 0", rsp_data, h_rsp_valid, oci_cmd_valid); end
    tick();
    tick();
    reset = 1'b0;
    oci_ack = 1'b1; oci_rdata = 32'hFFFF_FFFF; oci_err = 1'b1;
    tick();
    oci_ack = 1'b0; oci_err = 1'b0;
    n_cmp++; if (rsp_data !== 34'd0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rw_stray_ack: got data=%h busy=%b want 0 0", rsp_data, busy); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (h_rsp_valid !== 1'b0 || j_rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rw_no_rsp[%0d]: got h=%b j=%b want 0 0", k, h_rsp_valid, j_rsp_valid); end
    end
  endtask

  initial begin
    reset = 1'b1;
    j_valid = 1'b0; j_ir = 2'd0; j_data = 38'd0;
    h_valid = 1'b0; h_ir = 2'd0; h_data = 38'd0;
    oci_ack = 1'b0; oci_rdata = 32'd0; oci_err = 1'b0;
    j_rsp_ready = 1'b0; h_rsp_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_jtag_only();
    test_timeout();
    test_ack_timeout_tie();
    test_backpressure();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nios2_debug_cmd_sched.md
# nios2_debug_cmd_sched

Debug command scheduler between the CPU debug slave's system-clock side and the on-chip instrumentation (OCI) register/memory port. It arbitrates between two command sources: JTAG-originated commands (already synchronized into `clk`) and an optional local debug host. It issues one command at a time to the OCI, waits for completion or timeout, and returns a status/data response to the originating requester. It is sited next to the debug slave sysclk logic inside the Nios II CPU hierarchy.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1023: maximum WAIT cycles before a command is abandoned; legal range 2..1023.
- `HOST_ENABLE`, 1: 1 enables the local host requester; 0 disables it.

Ports:
- `clk` in 1: single system clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `j_valid` in 1, `j_ready` out 1, `j_ir` in 2, `j_data` in 38: JTAG command channel.
- `h_valid` in 1, `h_ready` out 1, `h_ir` in 2, `h_data` in 38: host command channel.
- `oci_cmd_valid` out 1: single-cycle command strobe to the OCI.
- `oci_ir` out 2, `oci_data` out 38: command fields, held stable from ISSUE until the return to IDLE.
- `oci_ack` in 1: OCI completion pulse.
- `oci_rdata` in 32: OCI read data, valid with `oci_ack`.
- `oci_err` in 1: OCI error flag, valid with `oci_ack`.
- `j_rsp_valid` out 1, `j_rsp_ready` in 1: JTAG response handshake.
- `h_rsp_valid` out 1, `h_rsp_ready` in 1: host response handshake.
- `rsp_data` out 34: response payload, shared by both requesters. Bits [31:0] are rdata, bit [32] is err, bit [33] is timeout.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out 1: 0 = JTAG, 1 = host; identifies the current or last grant.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE to ISSUE (command accept):
  - If any enabled `*_valid` is high, select one requester.
  - `*_ready` is combinational: high only in IDLE, and only for the selected requester.
  - The accepting handshake latches ir/data into `oci_ir`/`oci_data` and sets `grant_id`.
- Arbitration is round-robin:
  - On a tie, the requester not granted last wins.
  - After reset, the pointer favours JTAG.
  - A single requester is granted back-to-back without penalty.
- ISSUE: `oci_cmd_valid`=1 for exactly one cycle, then unconditional move to WAIT. `oci_ack` is ignored in ISSUE.
- WAIT: a 10-bit counter is cleared on entry and increments each WAIT cycle without `oci_ack`.
  - `oci_ack`=1: capture `oci_rdata` and `oci_err` into `rsp_data`, set timeout=0, go to RESP.
  - No ack while count == `TIMEOUT_CYCLES`-1: set `rsp_data` = {1'b1, 1'b0, 32'h0}, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
- RESP: `*_rsp_valid` is high for the granted requester only.
  - `rsp_data` is stable while valid.
  - A `*_rsp_ready` handshake returns the FSM to IDLE and advances the round-robin pointer.
  - The other requester's `rsp_ready` is ignored.
- `oci_ack` outside WAIT is discarded and does not alter `rsp_data`.
- `HOST_ENABLE`=0: `h_ready` and `h_rsp_valid` are tied 0, and `h_valid` is ignored.
- `j_ir`/`h_ir` values 0..3 pass through unmodified; no decoding is done here.

## Timing
- Reset values (applied asynchronously while `reset`=1):
  - FSM = IDLE; `oci_cmd_valid`=0; `oci_ir`=0; `oci_data`=0.
  - `rsp_data`=0; both `rsp_valid`=0; `busy`=0; `grant_id`=0; round-robin pointer = JTAG; counter = 0.
  - `*_ready` is 0 during reset.
- Reset mid-command abandons the command; no response is issued after reset deasserts.
- Latency with accept at cycle T:
  - `oci_cmd_valid` at T+1.
  - Earliest usable `oci_ack` at T+2.
  - `*_rsp_valid` at T+3.
  - Earliest next accept at T+4, with `rsp_ready` held high.
- Timeout response: `rsp_valid` rises `TIMEOUT_CYCLES`+2 cycles after accept.
- Throughput: at most one command in flight. A requester's `valid` held during another's transaction is served at the next IDLE.
- `rsp_valid` and `rsp_data` are registered outputs; `ready` is combinational from state, valid and pointer.

## Test plan
- JTAG only: `j_ir`=2, `j_data`=38'h2_0000_0ABC; `oci_ack` at T+2 with rdata=32'hDEADBEEF, err=0.
  - Required: `oci_cmd_valid` only at T+1, `oci_data`=38'h2_0000_0ABC, `j_rsp_valid` at T+3, `rsp_data`=34'h0_DEADBEEF.
- Simultaneous valid from reset: first grant to JTAG, second to host (`grant_id` 0 then 1). Both held valid for four commands gives grants J,H,J,H.
- No ack with `TIMEOUT_CYCLES`=8:
  - Required: `rsp_valid` at T+10, `rsp_data`=34'h2_00000000, then return to IDLE after `rsp_ready`.
- Ack and timeout in the same cycle, with rdata=32'h1 and err=1: `rsp_data`=34'h1_00000001.
- `rsp_ready` backpressure: hold `j_rsp_ready`=0 for 5 cycles while `h_valid`=1.
  - Required: `rsp_data` stable, `h_ready`=0 throughout, host accepted in the cycle after the JTAG response handshake.
- Reset asserted during WAIT:
  - Required: all outputs at reset values in the same cycle; no `rsp_valid` after release; a stray `oci_ack` after release is ignored.
